// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and byte-output bundle for the UART receiver
`timescale 1ns/1ps

interface uart_rx_if #(
  parameter int N = 8
);
  logic         i_rx;
  logic [N-1:0] o_data;
  logic         o_rx_valid;
  logic         o_frame_err;

  modport master (
    input  i_rx,
    output o_data,
    output o_rx_valid,
    output o_frame_err
  );

  modport slave (
    output i_rx,
    input  o_data,
    input  o_rx_valid,
    input  o_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampling, internal baud tick
`timescale 1ns/1ps

module uart_rx #(
  parameter int N          = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 19200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.master  rx_if
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(N - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    s_cnt_q, s_cnt_d;
  logic [NW-1:0] n_cnt_q, n_cnt_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic          tick;

  // Tick phase is free-running and never re-aligned to the start edge.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    div_d   = tick ? '0 : div_q + DW'(1);
    sync1_d = rx_if.i_rx;
    rx_s_d  = sync1_q;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = 4'd0;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = 4'd0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_q == 4'd15) begin
            shreg_d = {rx_s_q, shreg_q[N-1:1]};
            s_cnt_d = 4'd0;
            if (n_cnt_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught from IDLE.
        if (tick) begin
          if (s_cnt_q == 4'd15) begin
            if (rx_s_q) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ferr_d  = 1'b1;
            end
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      s_cnt_q <= 4'd0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_rx_valid  = valid_q;
  assign rx_if.o_frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 160 clk per bit
`timescale 1ns/1ps

module tb_uart_rx;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if #(.N(8)) bus ();

  uart_rx #(
    .N(8), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_if(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  longint     vt[$];
  longint     cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // The stop bit of a bad frame is low only over its first 5/8 so the tail cannot look like a new start.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int bit_clk);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = stop_ok ? b : last_good;
    if (stop_ok) last_good = b;
    sb.push_back(e);
    bus.i_rx = 1'b0;
    repeat (bit_clk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.i_rx = b[i];
      repeat (bit_clk) @(negedge clk);
    end
    if (stop_ok) begin
      bus.i_rx = 1'b1;
      repeat (bit_clk) @(negedge clk);
    end else begin
      bus.i_rx = 1'b0;
      repeat (bit_clk * 5 / 8) @(negedge clk);
      bus.i_rx = 1'b1;
      repeat (bit_clk - bit_clk * 5 / 8) @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    repeat (300) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.o_rx_valid || bus.o_frame_err)) begin
      check("pulse_exclusive", 32'(bus.o_rx_valid & bus.o_frame_err), 32'd0);
      if (bus.o_rx_valid) vt.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({bus.o_rx_valid, bus.o_frame_err}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", 32'({bus.o_rx_valid, bus.o_frame_err}),
              mon_e.is_err ? 32'd1 : 32'd2);
        check("pulse_data", 32'(bus.o_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    bus.i_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(bus.o_data), 32'd0);
    check("rst_valid", 32'(bus.o_rx_valid), 32'd0);
    check("rst_ferr", 32'(bus.o_frame_err), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    send(8'h03, 1'b1, BIT);
    drain("t1_drain");

    vt.delete();
    send(8'hA5, 1'b1, BIT);
    send(8'h5A, 1'b1, BIT);
    drain("t2_drain");
    check("t2_valid_count", 32'(vt.size()), 32'd2);
    if (vt.size() == 2)
      check("t2_gap_in_range", 32'((vt[1] - vt[0]) >= 1585 && (vt[1] - vt[0]) <= 1615), 32'd1);

    bus.i_rx = 1'b0;
    repeat (30) @(negedge clk);
    bus.i_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("t3_fsm_idle", 32'(dut.state_q), 32'd0);
    send(8'h01, 1'b1, BIT);
    drain("t3_drain");

    send(8'h11, 1'b1, BIT);
    send(8'hFF, 1'b0, BIT);
    drain("t4_drain");
    check("t4_data_held", 32'(bus.o_data), 32'h11);

    bus.i_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.i_rx = i[0] ? 1'b0 : 1'b1;
      repeat (BIT) @(negedge clk);
    end
    bus.i_rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_data", 32'(bus.o_data), 32'd0);
    check("t5_rst_valid", 32'(bus.o_rx_valid), 32'd0);
    check("t5_rst_ferr", 32'(bus.o_frame_err), 32'd0);
    repeat (3) @(negedge clk);
    bus.i_rx = 1'b1;
    rst = 1'b0;
    last_good = 8'h00;
    repeat (400) @(negedge clk);
    check("t5_data_after", 32'(bus.o_data), 32'd0);
    send(8'h12, 1'b1, BIT);
    drain("t5_drain");

    send(8'hC3, 1'b1, 155);
    drain("t6_fast_drain");
    send(8'hC3, 1'b1, 165);
    drain("t6_slow_drain");
    check("t6_data", 32'(bus.o_data), 32'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
